// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with per-row dwell, blanking and a double-buffered frame load.
// Optional per-frame brightness PWM is enabled by defining SCAN_PWM_EN.
module led_matrix_scanner #(
  parameter int COLS           = 16,
  parameter int ROWS           = 8,
  parameter int DWELL          = 1024,
  parameter int BLANK          = 16,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLS*ROWS-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [COLS-1:0]      columns,
  output logic [ROWS-1:0]      rows,
  output logic                 frame_start
`ifdef SCAN_PWM_EN
  ,
  input  logic [3:0]           brightness
`endif
);

  localparam int FW = COLS * ROWS;
  localparam int KW = $clog2(DWELL);
  localparam int RW = $clog2(ROWS);
  localparam logic [KW-1:0]   K_LAST  = KW'(DWELL - 1);
  localparam logic [RW-1:0]   R_LAST  = RW'(ROWS - 1);
  localparam logic [COLS-1:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

  logic [KW-1:0]   kQ, kD;
  logic [RW-1:0]   rowQ, rowD;
  logic [FW-1:0]   activeQ, activeD;
  logic [FW-1:0]   shadowQ, shadowD;
  logic            shadowFullQ, shadowFullD;
  logic            frameReadyQ;
  logic [COLS-1:0] columnsQ, columnsD;
  logic [ROWS-1:0] rowsQ, rowsD;
  logic            frameStartQ, frameStartD;

  logic            frameEnd;
  logic            accept;
  logic            swap;
  logic            visible;
  logic            lit;
  logic [COLS-1:0] rowData;

  assign frameEnd = (rowQ == R_LAST) && (kQ == K_LAST);
  assign accept   = frame_valid && frameReadyQ;
  assign swap     = frameEnd && shadowFullQ;

  always_comb begin
    kD   = kQ + 1'b1;
    rowD = rowQ;
    if (kQ == K_LAST) begin
      kD   = '0;
      rowD = (rowQ == R_LAST) ? '0 : rowQ + 1'b1;
    end
  end

  // A swap and an acceptance never collide: acceptance needs an empty shadow.
  always_comb begin
    activeD     = activeQ;
    shadowD     = shadowQ;
    shadowFullD = shadowFullQ;
    if (swap) begin
      activeD     = shadowQ;
      shadowFullD = 1'b0;
    end
    if (accept) begin
      shadowD     = frame_data;
      shadowFullD = 1'b1;
    end
  end

  always_comb begin
    rowData = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rowQ == RW'(r)) rowData = activeQ[(ROWS-r)*COLS-1 -: COLS];
    end
  end

  generate
    if (BLANK == 0) begin : gNoBlank
      assign visible = 1'b1;
    end else begin : gBlank
      localparam logic [KW-1:0] K_BLANK = KW'(BLANK);
      assign visible = (kQ >= K_BLANK);
    end
  endgenerate

`ifdef SCAN_PWM_EN
  localparam int V  = DWELL - BLANK;
  localparam int PW = $clog2(DWELL + 1) + 5;

  logic [3:0]    brightQ, brightD;
  logic [PW-1:0] onCount;
  logic [PW-1:0] phase;

  // Brightness only changes on frame boundaries so a frame is never split.
  assign brightD = frameEnd ? brightness : brightQ;
  assign onCount = (PW'(V) * ({{(PW-4){1'b0}}, brightQ} + PW'(1))) >> 4;
  assign phase   = {{(PW-KW){1'b0}}, kQ} - PW'(BLANK);
  assign lit     = (phase < onCount);

  always_ff @(posedge clk) begin
    if (rst) brightQ <= 4'hF;
    else     brightQ <= brightD;
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    rowsD       = '0;
    columnsD    = COL_OFF;
    frameStartD = (rowQ == '0) && (kQ == '0);
    if (visible) begin
      rowsD = ROWS'(1) << rowQ;
      if (lit) columnsD = rowData ^ COL_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kQ          <= '0;
      rowQ        <= '0;
      activeQ     <= '0;
      shadowQ     <= '0;
      shadowFullQ <= 1'b0;
      frameReadyQ <= 1'b0;
      columnsQ    <= COL_OFF;
      rowsQ       <= '0;
      frameStartQ <= 1'b0;
    end else begin
      kQ          <= kD;
      rowQ        <= rowD;
      activeQ     <= activeD;
      shadowQ     <= shadowD;
      shadowFullQ <= shadowFullD;
      frameReadyQ <= ~shadowFullD;
      columnsQ    <= columnsD;
      rowsQ       <= rowsD;
      frameStartQ <= frameStartD;
    end
  end

  assign frame_ready = frameReadyQ;
  assign columns     = columnsQ;
  assign rows        = rowsQ;
  assign frame_start = frameStartQ;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Drives two scanners (active-high and active-low columns) from one stimulus stream and
// compares them every cycle against a frame-position reference model.
module tb_led_matrix_scanner;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ROWS * DWELL;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       readyA, readyB, startA, startB;
  logic [3:0] colsA, colsB;
  logic [1:0] rowsA, rowsB;
`ifdef SCAN_PWM_EN
  logic [3:0] brightness;
`endif

  int testsRun  = 0;
  int failCount = 0;

  // Reference model state: n counts non-reset edges since the last reset.
  int         n;
  logic [7:0] mActive, mShadow;
  bit         mFull, mReady, mAccepted;
  int         mBright;
  logic [1:0] expRows;
  logic [3:0] expColsA, expColsB;
  bit         expStart;

  always #5 clk = ~clk;

  led_matrix_scanner #(.COLS(COLS), .ROWS(ROWS), .DWELL(DWELL), .BLANK(BLANK), .COL_ACTIVE_LOW(0)) dutA (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(readyA), .columns(colsA), .rows(rowsA), .frame_start(startA)
`ifdef SCAN_PWM_EN
    , .brightness(brightness)
`endif
  );

  led_matrix_scanner #(.COLS(COLS), .ROWS(ROWS), .DWELL(DWELL), .BLANK(BLANK), .COL_ACTIVE_LOW(1)) dutB (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(readyB), .columns(colsB), .rows(rowsB), .frame_start(startB)
`ifdef SCAN_PWM_EN
    , .brightness(brightness)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h at n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic modelEdge();
    int pos, row, k, onCount;
    logic [3:0] data;
    bit lit;
    mAccepted = 1'b0;
    if (rst) begin
      n = 0; mActive = '0; mShadow = '0; mFull = 0; mReady = 0; mBright = 15;
      expRows = '0; expColsA = 4'h0; expColsB = 4'hF; expStart = 0;
    end else begin
      pos = n % FRAME;
      row = pos / DWELL;
      k   = pos % DWELL;
      data = (row == 0) ? mActive[7:4] : mActive[3:0];
      onCount = ((DWELL - BLANK) * (mBright + 1)) / 16;
`ifdef SCAN_PWM_EN
      lit = (k - BLANK) < onCount;
`else
      lit = 1'b1;
`endif
      expStart = (pos == 0);
      expRows  = (k >= BLANK) ? 2'(1 << row) : 2'b00;
      expColsA = (k >= BLANK && lit) ? data : 4'h0;
      expColsB = ~expColsA;
      mAccepted = frame_valid && mReady;
      if (pos == FRAME - 1) begin
        if (mFull) begin
          mActive = mShadow;
          mFull = 0;
        end
`ifdef SCAN_PWM_EN
        mBright = int'(brightness);
`endif
      end
      if (mAccepted) begin
        mShadow = frame_data;
        mFull = 1;
      end
      mReady = !mFull;
      n++;
    end
  endtask

  task automatic checkOutput();
    check("rowsA", {6'b0, rowsA}, {6'b0, expRows});
    check("rowsB", {6'b0, rowsB}, {6'b0, expRows});
    check("colsA", {4'b0, colsA}, {4'b0, expColsA});
    check("colsB", {4'b0, colsB}, {4'b0, expColsB});
    check("readyA", {7'b0, readyA}, {7'b0, mReady});
    check("readyB", {7'b0, readyB}, {7'b0, mReady});
    check("startA", {7'b0, startA}, {7'b0, expStart});
    check("startB", {7'b0, startB}, {7'b0, expStart});
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  task automatic offer(input logic [7:0] d);
    bit done = 0;
    frame_valid = 1'b1;
    frame_data  = d;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      applyStimulus(1);
      if (mAccepted) done = 1;
    end
    frame_valid = 1'b0;
    check("offerAccepted", {7'b0, done}, 8'h01);
  endtask

  task automatic runToPos(input int target);
    for (int i = 0; i < FRAME && (n % FRAME) != target; i++) applyStimulus(1);
    check("reachedPos", 8'(n % FRAME), 8'(target));
  endtask

  initial begin
    rst = 1'b1;
    frame_valid = 1'b0;
    frame_data = 8'h00;
`ifdef SCAN_PWM_EN
    brightness = 4'hF;
`endif
    #1;
    applyStimulus(3);
    check("resetRows", {6'b0, rowsA}, 8'h00);
    check("resetColsLow", {4'b0, colsB}, 8'h0F);

    rst = 1'b0;
    applyStimulus(1);
    check("firstStart", {7'b0, startA}, 8'h01);
    check("firstReady", {7'b0, readyA}, 8'h01);
    applyStimulus(3);

    // Mid-row-0 load, then two frames so the swap and both row slices are seen.
    offer(8'hA5);
    applyStimulus(2 * FRAME);

    // Back-to-back: second frame waits for the boundary.
    offer(8'h11);
    offer(8'h22);
    applyStimulus(3 * FRAME);

    // Reset at row 1, k=5 with a frame pending in the shadow buffer.
    runToPos(0);
    offer(8'h3C);
    runToPos(DWELL + 5);
    rst = 1'b1;
    applyStimulus(1);
    check("midResetRows", {6'b0, rowsA}, 8'h00);
    check("midResetCols", {4'b0, colsA}, 8'h00);
    rst = 1'b0;
    applyStimulus(2 * FRAME);
    check("noPendingShown", mActive, 8'h00);

`ifdef SCAN_PWM_EN
    brightness = 4'd7;
    offer(8'hFF);
    applyStimulus(3 * FRAME);
`endif

    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      frame_valid = ($urandom_range(0, 2) == 0);
      frame_data  = 8'($urandom);
`ifdef SCAN_PWM_EN
      brightness  = 4'($urandom);
`endif
      applyStimulus(1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Parametrised row-multiplexed LED matrix driver. Successor to the fixed 16x8 scanner.
- Adds per-row dwell time, anti-ghosting blanking, a double-buffered frame load with valid/ready handshake, column polarity selection, and a frame-start strobe.
- Sits between the frame producer (pattern/text logic) and the matrix pins.

Parameters:
- COLS, 16, number of column lines (columns width).
- ROWS, 8, number of row lines (rows width, one-hot scan). Must be >= 2.
- DWELL, 1024, clocks per row slot, blanking included. Must be >= 2.
- BLANK, 16, clocks at the start of each row slot with the row driven off. Must satisfy 0 <= BLANK < DWELL.
- COL_ACTIVE_LOW, 0, when 1 a lit column is driven 0 and the column "off" value is all ones.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- frame_data  in  COLS*ROWS  new frame; row r uses slice frame_data[(ROWS-r)*COLS-1 -: COLS], so row 0 is the top slice.
- frame_valid  in  1  producer offers frame_data.
- frame_ready  out  1  block can accept a frame.
- columns  out  COLS  column drive, registered.
- rows  out  ROWS  row drive, one-hot active-high, registered.
- frame_start  out  1  one-cycle pulse on the first output cycle of row 0.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: rows=0, columns=off value (0, or all ones if COL_ACTIVE_LOW), frame_start=0, frame_ready=0, row index=0, slot counter k=0, active buffer=0, shadow buffer empty.
- First cycle after rst deasserts: frame_ready=1; scanning starts at row 0, k=0.
- Slot counter k counts 0..DWELL-1 per row. On k=DWELL-1 it wraps to 0 and the row index advances. The row index wraps from ROWS-1 to 0.
- Output timing: outputs are registered and show the state (row, k) of the previous cycle, i.e. one-cycle latency.
  - k < BLANK: rows=0, columns=off value.
  - k >= BLANK: rows=1<<row, columns=active slice for that row, inverted if COL_ACTIVE_LOW.
- frame_start is 1 exactly on the output cycle for row 0, k=0.
- Handshake: a frame is accepted on a posedge where frame_valid=1 and frame_ready=1.
  - The frame is stored in the shadow buffer and marks it full.
  - frame_ready equals NOT shadow_full; it is registered and deasserts the cycle after acceptance.
  - frame_valid with frame_ready=0 is ignored; the producer holds its data.
- Frame boundary (row=ROWS-1, k=DWELL-1): if the shadow buffer is full, copy it to the active buffer and clear shadow_full. frame_ready rises the next cycle.
  - The new frame is first displayed in the following row-0 slot.
  - The display never changes mid-frame.
- Acceptance on the boundary cycle: possible only when the shadow buffer was already empty. The frame is captured into the shadow buffer and is not swapped until the next boundary.
- Before any frame has been loaded, the display shows the all-zero active buffer: columns at the off value, rows still scanning.
- Reset mid-operation: on the next edge all state returns to reset values. The active buffer is cleared and any pending shadow frame is discarded.
- Width rules: k register is clog2(DWELL) bits; row register is clog2(ROWS) bits; no arithmetic overflow is permitted.

Optional Feature:
- Macro: SCAN_PWM_EN.
- Defined: adds port brightness, in, 4 bits.
  - brightness is sampled into a register at every frame boundary and at reset (reset value 15).
  - Let V = DWELL-BLANK. During k >= BLANK, columns show row data only while (k-BLANK) < ((V*(b+1))>>4); otherwise columns=off value while rows stay asserted.
  - b=15 gives full on-time.
- Undefined: no brightness port; columns are lit for the whole visible portion.

Test Plan:
Parameters for all scenarios: COLS=4, ROWS=2, DWELL=8, BLANK=2, unless noted.
- Reset: hold rst 3 cycles -> rows=00, columns=0000, frame_ready=0, frame_start=0. Release rst -> frame_ready=1 next cycle; frame_start pulses on the first output cycle.
- Load 8'hA5 mid-row-0 -> frame_ready drops next cycle; zeros continue to the boundary. Then per row slot: row 0 = 2 cycles rows=00/cols=0000, then 6 cycles rows=01/cols=1010; row 1 = 2 blank cycles, then 6 cycles rows=10/cols=0101. frame_ready=1 again after the swap.
- Back-to-back: accept 8'h11, then hold frame_valid with 8'h22 -> frame_ready stays 0 until the boundary. 8'h22 is accepted the cycle frame_ready returns and first displays one frame after 8'h11.
- Reset at row 1, k=5 with a shadow frame pending -> next cycle rows=00, columns=0000. After release the pending frame is not displayed and frame_ready=1.
- COL_ACTIVE_LOW=1, frame 8'hA5 -> blank cycles columns=1111; row 0 visible cycles columns=0101.
- SCAN_PWM_EN, brightness=7 (V=6) -> per row: 2 blank cycles, 3 cycles with data, 3 cycles with rows asserted and columns at the off value. brightness=15 -> 6 data cycles.
